// File: rtl/noc_pkg.sv
// Shared types and constants for the multicast router pipe.
// The top-level noc_router_mcpipe gains statistics ports under NOC_ROUTER_MCPIPE_STATS_EN.
package noc_pkg;

  localparam int NOC_DATA_W  = 256;
  localparam int NOC_OUTPUTS = 5;
  localparam int NOC_STAT_W  = 32;

  typedef logic [NOC_OUTPUTS-1:0] flit_mask_t;

  typedef struct packed {
    logic [NOC_DATA_W-1:0] data;
    flit_mask_t            mask;
  } mcpipe_entry_t;

  function automatic logic [NOC_STAT_W-1:0] sat_inc(input logic [NOC_STAT_W-1:0] v);
    return (&v) ? v : v + NOC_STAT_W'(1);
  endfunction

endpackage

// File: rtl/noc_mcpipe_store.sv
// DEPTH-entry flit store: circular register array with modulo-DEPTH pointers.
// full is a flop so the upstream ready never depends on this cycle's pop.
module noc_mcpipe_store #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_entry,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (pop && !push)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  // Payload storage is deliberately unreset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_entry;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/noc_router_mcpipe.sv
// Multicast forward/backward buffer: each destination takes the head flit independently.
// Optional statistics ports are enabled with NOC_ROUTER_MCPIPE_STATS_EN.
module noc_router_mcpipe
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_W,
  parameter int OUTPUTS    = NOC_OUTPUTS,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [OUTPUTS-1:0]    in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OUTPUTS-1:0]    out_valid,
  input  logic [OUTPUTS-1:0]    out_ready
`ifdef NOC_ROUTER_MCPIPE_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [NOC_STAT_W-1:0] stat_flits,
  output logic [NOC_STAT_W-1:0] stat_stall
`endif
);

  localparam int EW = DATA_WIDTH + OUTPUTS;

  logic [EW-1:0]      head;
  logic [OUTPUTS-1:0] head_mask;
  logic [OUTPUTS-1:0] served;
  logic [OUTPUTS-1:0] accepted;
  logic               full;
  logic               empty;
  logic               push;
  logic               retire;

  assign push = (|in_valid) && in_ready;

  noc_mcpipe_store #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (retire),
    .wr_entry ({in_data, in_valid}),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  assign in_ready              = ~full;
  assign {out_data, head_mask} = head;
  assign out_valid             = empty ? '0 : (head_mask & ~served);
  assign accepted              = out_valid & out_ready;
  assign retire                = !empty && ((served | accepted) == head_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      served <= '0;
    else if (retire)
      served <= '0;
    else
      served <= served | accepted;
  end

`ifdef NOC_ROUTER_MCPIPE_STATS_EN
  logic stall;
  assign stall = (|out_valid) && !(|accepted);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_flits <= '0;
      stat_stall <= '0;
    end else if (stat_clr) begin
      stat_flits <= '0;
      stat_stall <= '0;
    end else begin
      if (retire)
        stat_flits <= sat_inc(stat_flits);
      if (stall)
        stat_stall <= sat_inc(stat_stall);
    end
  end
`endif

`ifndef SYNTHESIS
  // Upstream may withdraw a blocked offer but must not swap it for another mask.
  a_mask_hold: assert property (@(posedge clk) disable iff (!rst_n)
    ((|in_valid) && !in_ready) |=> ((in_valid == $past(in_valid)) || (in_valid == '0)))
    else $error("in_valid mask changed while flit pending");
`endif

endmodule

// File: tb/tb_noc_router_mcpipe.sv
// Self-checking bench: DEPTH=2 and DEPTH=4 instances against a queue-based reference model.
module tb_noc_router_mcpipe;

  localparam int DW = 32;
  localparam int O  = 5;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [O-1:0]  mask;
  } ent_t;

  typedef struct packed {
    logic [O-1:0] ready;
    logic [O-1:0] exp_valid;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data   [2];
  logic [O-1:0]  in_valid  [2];
  logic          in_ready  [2];
  logic [DW-1:0] out_data  [2];
  logic [O-1:0]  out_valid [2];
  logic [O-1:0]  out_ready [2];
`ifdef NOC_ROUTER_MCPIPE_STATS_EN
  logic          stat_clr   [2];
  logic [31:0]   stat_flits [2];
  logic [31:0]   stat_stall [2];
  logic [31:0]   m_flits    [2];
  logic [31:0]   m_stall    [2];
`endif

  int   checks = 0;
  int   errors = 0;
  int   depth [2] = '{2, 4};
  ent_t mq [2][$];
  logic [O-1:0] m_served [2];
  bit   blocked [2];

  always #5 clk = ~clk;

  noc_router_mcpipe #(.DATA_WIDTH(DW), .OUTPUTS(O), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0])
`ifdef NOC_ROUTER_MCPIPE_STATS_EN
    , .stat_clr(stat_clr[0]), .stat_flits(stat_flits[0]), .stat_stall(stat_stall[0])
`endif
  );

  noc_router_mcpipe #(.DATA_WIDTH(DW), .OUTPUTS(O), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1])
`ifdef NOC_ROUTER_MCPIPE_STATS_EN
    , .stat_clr(stat_clr[1]), .stat_flits(stat_flits[1]), .stat_stall(stat_stall[1])
`endif
  );

  // Reference model: a queue of flits plus the set of destinations already served.
  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        mq[d].delete();
        m_served[d] = '0;
        blocked[d]  = 1'b0;
`ifdef NOC_ROUTER_MCPIPE_STATS_EN
        m_flits[d] = 0;
        m_stall[d] = 0;
`endif
      end else begin
        int sz;
        logic [O-1:0] vis, acc;
        bit ret, psh;
        sz  = mq[d].size();
        vis = (sz > 0) ? (mq[d][0].mask & ~m_served[d]) : '0;
        acc = vis & out_ready[d];
        ret = (sz > 0) && ((m_served[d] | acc) == mq[d][0].mask);
        psh = (in_valid[d] != '0) && (sz < depth[d]);
        blocked[d] = (in_valid[d] != '0) && (sz >= depth[d]);
`ifdef NOC_ROUTER_MCPIPE_STATS_EN
        if (stat_clr[d]) begin
          m_flits[d] = 0;
          m_stall[d] = 0;
        end else begin
          if (ret && m_flits[d] != 32'hFFFF_FFFF) m_flits[d] = m_flits[d] + 1;
          if (vis != '0 && acc == '0 && m_stall[d] != 32'hFFFF_FFFF) m_stall[d] = m_stall[d] + 1;
        end
`endif
        if (ret) begin
          void'(mq[d].pop_front());
          m_served[d] = '0;
        end else begin
          m_served[d] = m_served[d] | acc;
        end
        if (psh) mq[d].push_back('{data: in_data[d], mask: in_valid[d]});
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input int d);
    logic [O-1:0] ev;
    ev = (mq[d].size() > 0) ? (mq[d][0].mask & ~m_served[d]) : '0;
    chk($sformatf("d%0d out_valid", d), 64'(out_valid[d]), 64'(ev));
    chk($sformatf("d%0d in_ready", d), 64'(in_ready[d]), 64'(mq[d].size() < depth[d]));
    if (mq[d].size() > 0)
      chk($sformatf("d%0d out_data", d), 64'(out_data[d]), 64'(mq[d][0].data));
`ifdef NOC_ROUTER_MCPIPE_STATS_EN
    chk($sformatf("d%0d stat_flits", d), 64'(stat_flits[d]), 64'(m_flits[d]));
    chk($sformatf("d%0d stat_stall", d), 64'(stat_stall[d]), 64'(m_stall[d]));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all(0);
    check_all(1);
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = '0;
      in_data[d]   = '0;
      out_ready[d] = '0;
`ifdef NOC_ROUTER_MCPIPE_STATS_EN
      stat_clr[d] = 1'b0;
`endif
    end
  endtask

  vec_t mc_tab [5];

  initial begin
    mc_tab[0] = '{ready: 5'b00010, exp_valid: 5'b10110};
    mc_tab[1] = '{ready: 5'b10000, exp_valid: 5'b10100};
    mc_tab[2] = '{ready: 5'b10010, exp_valid: 5'b00100};
    mc_tab[3] = '{ready: 5'b00100, exp_valid: 5'b00100};
    mc_tab[4] = '{ready: 5'b00000, exp_valid: 5'b00000};

    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all(0);
    check_all(1);
    chk("reset out_valid", 64'(out_valid[1]), 64'h0);
    chk("reset in_ready", 64'(in_ready[0]), 64'h1);

    // Unicast stream through DEPTH=2: one flit per cycle, latency 1.
    out_ready[0] = '1;
    for (int k = 0; k < 8; k++) begin
      in_valid[0] = 5'b00001;
      in_data[0]  = 32'hA000 + k;
      tick();
      chk("stream valid", 64'(out_valid[0]), 64'h1);
      chk("stream data", 64'(out_data[0]), 64'(32'hA000 + k));
      chk("stream ready", 64'(in_ready[0]), 64'h1);
    end
    in_valid[0] = '0;
    tick();
    chk("stream drained", 64'(out_valid[0]), 64'h0);
    out_ready[0] = '0;

    // Multicast partial accepts on DEPTH=4.
    in_valid[1] = 5'b10110;
    in_data[1]  = 32'hBEEF;
    tick();
    in_valid[1] = '0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mcast valid t%0d", i), 64'(out_valid[1]), 64'(mc_tab[i].exp_valid));
      if (mc_tab[i].exp_valid != '0)
        chk($sformatf("mcast data t%0d", i), 64'(out_data[1]), 64'hBEEF);
      out_ready[1] = mc_tab[i].ready;
      tick();
    end
    out_ready[1] = '0;

    // Fill DEPTH=4, drop a push at full, then one pop reopens the input next cycle.
    for (int k = 0; k < 4; k++) begin
      in_valid[1] = 5'b00011;
      in_data[1]  = 32'h100 + k;
      tick();
    end
    chk("full in_ready", 64'(in_ready[1]), 64'h0);
    in_data[1] = 32'h999;
    tick();
    in_valid[1] = '0;
    chk("drop keeps full", 64'(in_ready[1]), 64'h0);
    out_ready[1] = 5'b00011;
    tick();
    chk("ready after pop", 64'(in_ready[1]), 64'h1);
    for (int k = 1; k < 4; k++) begin
      chk("fill order", 64'(out_data[1]), 64'(32'h100 + k));
      tick();
    end
    chk("fill drained", 64'(out_valid[1]), 64'h0);
    out_ready[1] = '0;

    // Zero mask is never stored.
    in_valid[1] = '0;
    in_data[1]  = 32'h5555;
    repeat (3) tick();
    chk("zero mask valid", 64'(out_valid[1]), 64'h0);
    chk("zero mask ready", 64'(in_ready[1]), 64'h1);

`ifdef NOC_ROUTER_MCPIPE_STATS_EN
    stat_clr[0] = 1'b1;
    tick();
    stat_clr[0] = 1'b0;
    in_valid[0] = 5'b00001; in_data[0] = 32'h1;
    tick();
    in_data[0] = 32'h2;
    tick();
    in_valid[0] = '0;
    repeat (2) tick();
    out_ready[0] = '1;
    repeat (2) tick();
    out_ready[0] = '0;
    chk("stat_stall", 64'(stat_stall[0]), 64'd3);
    chk("stat_flits", 64'(stat_flits[0]), 64'd2);
    stat_clr[0] = 1'b1;
    tick();
    stat_clr[0] = 1'b0;
    chk("stat_stall clr", 64'(stat_stall[0]), 64'd0);
    chk("stat_flits clr", 64'(stat_flits[0]), 64'd0);
`endif

    // Randomized traffic on both instances against the model.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (blocked[d]) begin
          if ($urandom_range(1, 0) == 0) in_valid[d] = '0;
        end else begin
          in_valid[d] = ($urandom_range(2, 0) == 0) ? '0 : O'($urandom);
          in_data[d]  = $urandom;
        end
        out_ready[d] = ($urandom_range(3, 0) == 0) ? '1 : O'($urandom);
`ifdef NOC_ROUTER_MCPIPE_STATS_EN
        stat_clr[d] = ($urandom_range(31, 0) == 0);
`endif
      end
      tick();
    end

    // Reset mid-traffic discards everything.
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst out_valid d2", 64'(out_valid[0]), 64'h0);
    chk("rst out_valid d4", 64'(out_valid[1]), 64'h0);
    chk("rst in_ready d4", 64'(in_ready[1]), 64'h1);
    rst_n = 1'b1;
    out_ready[0] = '1;
    out_ready[1] = '1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no stale d2", 64'(out_valid[0]), 64'h0);
      chk("no stale d4", 64'(out_valid[1]), 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
